// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg: op codes, FSM states and operand helpers for the iterative multiply/divide unit.
package mult_div_unit_pkg;
    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam int MDU_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mduState_e;

    function automatic logic [31:0] magnitude(input logic [31:0] value, input logic isSigned);
        return (isSigned && value[31]) ? -value : value;
    endfunction
endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one radix-2 step, shift-add multiply or restoring divide on a 64-bit accumulator.
module mdu_iter_step (
    input  logic        isDiv,
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    output logic [63:0] accNext
);
    logic [32:0] sum;
    logic [32:0] trial;
    logic [31:0] diff;
    always_comb begin
        sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        trial = acc[63:31];
        diff = trial[31:0] - operand;
        // divide keeps {remainder, dividend/quotient}; a successful trial shifts in a 1
        accNext = !isDiv ? {sum, acc[31:1]}
                : (trial >= {1'b0, operand}) ? {diff, acc[30:0], 1'b1}
                : {acc[62:0], 1'b0};
    end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers and single-cycle MTHI/MTLO.
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] OperandA,
    input  logic [31:0] OperandB,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    mduState_e state, nextState;
    logic [5:0]  count;
    logic [2:0]  opReg;
    logic        signA, signB, divZero;
    logic [63:0] acc, accNext, product;
    logic [31:0] operand, quo, rem;
    logic        accept, isSignedOp, isDivOp, negQ, negR;

    assign accept = state == IDLE && Start && Op <= MDU_DIVU;
    assign isSignedOp = opReg == MDU_MULT || opReg == MDU_DIV;
    assign isDivOp = opReg == MDU_DIV || opReg == MDU_DIVU;
    assign Busy = state != IDLE;

    mdu_iter_step uStep (
        .isDiv  (isDivOp),
        .acc    (acc),
        .operand(operand),
        .accNext(accNext)
    );

    always_ff @(posedge Clk) begin
        if (!ResetN) state <= IDLE;
        else state <= nextState;
    end

    always_comb begin
        nextState = accept ? CALC
                  : (state == CALC && count == 6'(MDU_ITERS - 1)) ? FINISH
                  : (state == FINISH) ? IDLE
                  : state;
    end

    // signed results are produced from magnitudes and corrected once at the end
    always_comb begin
        negQ = isSignedOp && (signA ^ signB);
        negR = isSignedOp && signA;
        product = negQ ? -acc : acc;
        quo = divZero ? '1 : negQ ? -acc[31:0] : acc[31:0];
        rem = negR ? -acc[63:32] : acc[63:32];
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            count <= '0;
            opReg <= '0;
            signA <= 1'b0;
            signB <= 1'b0;
            divZero <= 1'b0;
            acc <= '0;
            operand <= '0;
            Done <= 1'b0;
            Hi <= '0;
            Lo <= '0;
        end else begin
            Done <= state == FINISH;
            if (accept) begin
                count <= '0;
                opReg <= Op;
                signA <= OperandA[31];
                signB <= OperandB[31];
                divZero <= Op[1] && OperandB == '0;
                acc <= {32'd0, magnitude(OperandA, !Op[0])};
                operand <= magnitude(OperandB, !Op[0]);
            end else if (state == CALC) begin
                acc <= accNext;
                count <= count + 6'd1;
            end else if (state == FINISH) begin
                Hi <= isDivOp ? rem : product[63:32];
                Lo <= isDivOp ? quo : product[31:0];
            end
            if (state == IDLE && Start && Op == MDU_MTHI) Hi <= OperandA;
            if (state == IDLE && Start && Op == MDU_MTLO) Lo <= OperandA;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed and random checks of mult_div_unit against a plain-arithmetic reference model.
module tb_mult_div_unit;
    localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;

    logic        Clk = 1'b0;
    logic        ResetN, Start, Busy, Done;
    logic [2:0]  Op;
    logic [31:0] OperandA, OperandB, Hi, Lo;
    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    mult_div_unit dut (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .Start   (Start),
        .Op      (Op),
        .OperandA(OperandA),
        .OperandB(OperandB),
        .Busy    (Busy),
        .Done    (Done),
        .Hi      (Hi),
        .Lo      (Lo)
    );

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            OP_DIVU: return (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (!Done && lat < 40) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        logic [31:0] hi0, lo0;
        int lat;
        @(negedge Clk);
        hi0 = Hi;
        lo0 = Lo;
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(posedge Clk); #1;
        Start = 1'b0; OperandA = $urandom; OperandB = $urandom;
        check({tag, " busy"}, 64'(Busy), 64'd1);
        lat = 0;
        while (!Done && lat < 40) begin
            if (lat == 4) begin
                Start = 1'b1; Op = 3'($urandom_range(0, 7)); OperandA = 32'hDEADBEEF;
            end
            if (lat == 5) Start = 1'b0;
            @(posedge Clk); #1;
            lat++;
            if (lat == 20) check({tag, " hold"}, {Hi, Lo}, {hi0, lo0});
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " result"}, {Hi, Lo}, exp);
        check({tag, " busy_clr"}, 64'(Busy), 64'd0);
        @(posedge Clk); #1;
        check({tag, " done_pulse"}, 64'(Done), 64'd0);
    endtask

    initial begin
        int lat;
        logic sawDone;
        logic [2:0] rop;
        logic [31:0] ra, rb;
        ResetN = 1'b0; Start = 1'b0; Op = 3'd0; OperandA = '0; OperandB = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset", {30'd0, Busy, Done, Hi, Lo}, 64'd0);
        ResetN = 1'b1;

        runOp("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        runOp("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);
        runOp("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        runOp("divu_big", OP_DIVU, 32'h80000000, 32'd3, 64'h00000002_2AAAAAAA);
        runOp("div_zero", OP_DIV, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF);
        runOp("div_negzero", OP_DIV, 32'h80000000, 32'd0, 64'h80000000_FFFFFFFF);
        runOp("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        runOp("divu_zero", OP_DIVU, 32'hCAFEF00D, 32'd0, 64'hCAFEF00D_FFFFFFFF);

        @(negedge Clk);
        Start = 1'b1; Op = OP_MTLO; OperandA = 32'h00000055;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("mtlo", {30'd0, Busy, Done, Lo}, 64'h55);
        @(negedge Clk);
        Start = 1'b1; Op = OP_MTHI; OperandA = 32'h0BADF00D;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("mthi", {Hi, Lo}, {32'h0BADF00D, 32'h00000055});
        @(negedge Clk);
        Start = 1'b1; Op = 3'd7; OperandA = 32'h11111111;
        @(posedge Clk); #1;
        Start = 1'b0;
        check("nop_op", {30'd0, Busy, Done, Hi}, {32'd0, 32'h0BADF00D});

        @(negedge Clk);
        Start = 1'b1; Op = OP_MULTU; OperandA = 32'd5; OperandB = 32'd7;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clk);
        #1;
        ResetN = 1'b0;
        @(posedge Clk); #1;
        check("abort_state", {30'd0, Busy, Done, Hi, Lo}, 64'd0);
        ResetN = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge Clk); #1;
            sawDone |= Done;
        end
        check("abort_no_done", {62'd0, sawDone, Busy}, 64'd0);

        @(negedge Clk);
        Start = 1'b1; Op = OP_MULTU; OperandA = 32'd2; OperandB = 32'd3;
        @(posedge Clk); #1;
        Op = OP_DIVU; OperandA = 32'd9; OperandB = 32'd2;
        waitDone(lat);
        check("b2b_lat1", 64'(lat), 64'd33);
        check("b2b_res1", {Hi, Lo}, 64'h00000000_00000006);
        @(posedge Clk); #1;
        check("b2b_accept", {62'd0, Busy, Done}, 64'd2);
        Start = 1'b0;
        waitDone(lat);
        check("b2b_lat2", 64'(lat), 64'd33);
        check("b2b_res2", {Hi, Lo}, 64'h00000001_00000004);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (i % 6 == 5) ra = 32'h80000000;
            runOp($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, model(rop, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
